// File: rtl/rename_pkg.sv
// Shared types and sizing for the register-rename stage.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rename_pkg;

    localparam int ARCH_REGS = 32;
    localparam int PHYS_REGS = 64;
    localparam int TAG_W     = $clog2(PHYS_REGS);

    typedef logic [TAG_W-1:0] tag_t;   // physical register tag
    typedef logic [4:0]       areg_t;  // architectural register index
    typedef logic [TAG_W:0]   cnt_t;   // free-list occupancy, 0..PHYS_REGS-1

    // Tags 0..ARCH_REGS-1 belong to the reset identity mapping;
    // the remainder start out free.
    localparam int FREE_AT_RESET = PHYS_REGS - ARCH_REGS;

endpackage

// File: rtl/rename_unit_if.sv
// Decode-to-rename bundle: instruction register fields, stall, commit free, rename results.
// Latency: n/a (signal bundle); results are combinational from the fields in the same cycle.
// Backpressure: stall_in from upstream; free_empty tells upstream to stall when rd != 0.
// Ports (master = decode/commit side, slave = rename_unit):
//   stall_in, commit_free, prd_free, rd, rs1, rs2 : master -> slave
//   tag_new, tag_old, tag_rs1, tag_rs2, free_empty : slave -> master
interface rename_unit_if;
    import rename_pkg::*;

    logic  stall_in;
    logic  commit_free;
    tag_t  prd_free;
    areg_t rd;
    areg_t rs1;
    areg_t rs2;
    tag_t  tag_new;
    tag_t  tag_old;
    tag_t  tag_rs1;
    tag_t  tag_rs2;
    logic  free_empty;

    modport master (
        output stall_in, commit_free, prd_free, rd, rs1, rs2,
        input  tag_new, tag_old, tag_rs1, tag_rs2, free_empty
    );

    modport slave (
        input  stall_in, commit_free, prd_free, rd, rs1, rs2,
        output tag_new, tag_old, tag_rs1, tag_rs2, free_empty
    );

endinterface

// File: rtl/rename_unit_free_list.sv
// Circular FIFO of free physical tags, preloaded with 32..63 at reset.
// Latency: head tag visible combinationally; push/pop take effect at the next clk edge.
// Backpressure: pops while empty and pushes while full (or of tag 0) are dropped.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   i_push, i_push_tag : enqueue a released tag at the tail
//   i_pop           : dequeue the head tag
//   o_head          : tag at the head of the list
//   o_empty         : list holds no tags
module free_list
    import rename_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic i_push,
    input  tag_t i_push_tag,
    input  logic i_pop,
    output tag_t o_head,
    output logic o_empty
);

    tag_t r_mem [PHYS_REGS];
    tag_t r_head;
    tag_t r_tail;
    cnt_t r_count;

    logic w_full;
    logic w_push_en;
    logic w_pop_en;

    // Tag 0 is reserved for x0 and must never become allocatable.
    // At most PHYS_REGS-1 tags can ever be free (x0 holds tag 0).
    assign w_full    = (r_count == cnt_t'(PHYS_REGS - 1));
    assign o_empty   = (r_count == '0);
    assign w_push_en = i_push && (i_push_tag != '0) && !w_full;
    assign w_pop_en  = i_pop && !o_empty;
    assign o_head    = r_mem[r_head];

    always_ff @(posedge clk) begin
        if (rst) begin
            // Every slot gets its own index; with head at ARCH_REGS and a
            // count of FREE_AT_RESET the live window is exactly 32..63.
            for (int i = 0; i < PHYS_REGS; i++) begin
                r_mem[i] <= tag_t'(i);
            end
            r_head  <= tag_t'(ARCH_REGS);
            r_tail  <= '0;
            r_count <= cnt_t'(FREE_AT_RESET);
        end else begin
            if (w_push_en) begin
                r_mem[r_tail] <= i_push_tag;
                r_tail        <= r_tail + tag_t'(1);
            end
            if (w_pop_en) begin
                r_head <= r_head + tag_t'(1);
            end
            // Concurrent push and pop leave the occupancy unchanged.
            case ({w_push_en, w_pop_en})
                2'b10:   r_count <= r_count + cnt_t'(1);
                2'b01:   r_count <= r_count - cnt_t'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/rename_unit.sv
// Register rename: RAT lookup for rs1/rs2/rd and fresh-tag allocation from the free list.
// Latency: all tag outputs combinational in the same cycle; RAT/free list update at posedge clk.
// Backpressure: no allocation while stall_in or free_empty; upstream must stall on free_empty with rd != 0.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   rn       : rename_unit_if.slave (instruction fields, stall, commit free in; tags, free_empty out)
module rename_unit
    import rename_pkg::*;
(
    input  logic clk,
    input  logic rst,
    rename_unit_if.slave rn
);

    tag_t r_rat [ARCH_REGS];

    logic w_alloc;
    logic w_empty;
    tag_t w_head;

    // Freed tags are only visible after the push lands, so a tag released
    // this cycle can never be handed out in the same cycle.
    assign w_alloc = !rn.stall_in && (rn.rd != '0) && !w_empty;

    free_list u_free_list (
        .clk        (clk),
        .rst        (rst),
        .i_push     (rn.commit_free),
        .i_push_tag (rn.prd_free),
        .i_pop      (w_alloc),
        .o_head     (w_head),
        .o_empty    (w_empty)
    );

    // Lookups read the pre-update table, so rs == rd sees the old mapping.
    // x0 is forced to tag 0 rather than relying on the table entry.
    assign rn.tag_rs1    = (rn.rs1 == '0) ? '0 : r_rat[rn.rs1];
    assign rn.tag_rs2    = (rn.rs2 == '0) ? '0 : r_rat[rn.rs2];
    assign rn.tag_old    = (rn.rd  == '0) ? '0 : r_rat[rn.rd];
    assign rn.tag_new    = w_alloc ? w_head : '0;
    assign rn.free_empty = w_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ARCH_REGS; i++) begin
                r_rat[i] <= tag_t'(i);
            end
        end else if (w_alloc) begin
            r_rat[rn.rd] <= w_head;
        end
    end

endmodule

// File: tb/tb_rename_unit.sv
// Directed self-checking bench for rename_unit.
// Latency: inputs driven after negedge, outputs sampled 1ns later, state advances at posedge.
// Backpressure: exercised via stall_in and by draining the free list.
module tb_rename_unit;
    import rename_pkg::*;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    rename_unit_if rn_if ();

    rename_unit u_dut (
        .clk (clk),
        .rst (rst),
        .rn  (rn_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs; outputs are valid on return, the state
    // update happens at the following posedge.
    task automatic drive(input logic stall, input int rd, input int rs1, input int rs2,
                         input logic cf, input int pf);
        @(negedge clk);
        rn_if.stall_in    = stall;
        rn_if.rd          = areg_t'(rd);
        rn_if.rs1         = areg_t'(rs1);
        rn_if.rs2         = areg_t'(rs2);
        rn_if.commit_free = cf;
        rn_if.prd_free    = tag_t'(pf);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst               = 1'b1;
        rn_if.stall_in    = 1'b0;
        rn_if.rd          = '0;
        rn_if.rs1         = '0;
        rn_if.rs2         = '0;
        rn_if.commit_free = 1'b0;
        rn_if.prd_free    = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst      = 1'b1;
        do_reset();

        // Reset state: identity RAT, list not empty, no allocation with rd=0.
        drive(0, 0, 5, 31, 0, 0);
        check("rst_empty",   32'(rn_if.free_empty), 0);
        check("rst_rs1",     32'(rn_if.tag_rs1), 5);
        check("rst_rs2",     32'(rn_if.tag_rs2), 31);
        check("rst_new",     32'(rn_if.tag_new), 0);

        // addi x2,x0,6
        drive(0, 2, 0, 6, 0, 0);
        check("c1_new", 32'(rn_if.tag_new), 32);
        check("c1_old", 32'(rn_if.tag_old), 2);
        check("c1_rs1", 32'(rn_if.tag_rs1), 0);
        check("c1_rs2", 32'(rn_if.tag_rs2), 6);
        // addi x3,x0,15
        drive(0, 3, 0, 0, 0, 0);
        check("c2_new", 32'(rn_if.tag_new), 33);
        check("c2_old", 32'(rn_if.tag_old), 3);
        // x2 = x2 op x3: sources see pre-update mapping
        drive(0, 2, 2, 3, 0, 0);
        check("c3_rs1", 32'(rn_if.tag_rs1), 32);
        check("c3_rs2", 32'(rn_if.tag_rs2), 33);
        check("c3_new", 32'(rn_if.tag_new), 34);
        check("c3_old", 32'(rn_if.tag_old), 32);

        // Stall holds allocation.
        drive(1, 5, 0, 0, 0, 0);
        check("stall_new", 32'(rn_if.tag_new), 0);
        check("stall_old", 32'(rn_if.tag_old), 5);
        drive(0, 5, 0, 0, 0, 0);
        check("unstall_new", 32'(rn_if.tag_new), 35);
        check("unstall_old", 32'(rn_if.tag_old), 5);

        // rd=0 does not consume a tag.
        drive(0, 0, 5, 0, 0, 0);
        check("rd0_new", 32'(rn_if.tag_new), 0);
        check("rd0_old", 32'(rn_if.tag_old), 0);
        check("rd0_rs1", 32'(rn_if.tag_rs1), 35);
        drive(0, 6, 0, 0, 0, 0);
        check("after_rd0_new", 32'(rn_if.tag_new), 36);

        // Drain the remaining 27 tags (37..63) into x8.
        for (int k = 0; k < 27; k++) begin
            drive(0, 8, 0, 0, 0, 0);
            check("drain_new", 32'(rn_if.tag_new), 32'(37 + k));
        end

        // Empty list: 33rd allocation is dropped.
        drive(0, 9, 0, 0, 0, 0);
        check("empty_flag", 32'(rn_if.free_empty), 1);
        check("empty_new",  32'(rn_if.tag_new), 0);
        check("empty_old",  32'(rn_if.tag_old), 9);
        check("x8_map",     32'(rn_if.tag_rs1), 0);

        // Free 7 while empty: no same-cycle bypass.
        drive(0, 9, 8, 0, 1, 7);
        check("free7_still_empty", 32'(rn_if.free_empty), 1);
        check("free7_new",         32'(rn_if.tag_new), 0);
        check("x8_last",           32'(rn_if.tag_rs2), 0);
        // Next cycle the list holds 7; also try freeing tag 0 (ignored).
        drive(0, 0, 8, 0, 1, 0);
        check("free7_cleared", 32'(rn_if.free_empty), 0);
        check("x8_tag",        32'(rn_if.tag_rs1), 63);
        drive(0, 9, 0, 0, 0, 0);
        check("alloc7_new", 32'(rn_if.tag_new), 7);
        check("alloc7_old", 32'(rn_if.tag_old), 9);
        // If tag 0 had been pushed the list would not be empty now.
        drive(0, 0, 9, 0, 0, 0);
        check("zero_free_ignored", 32'(rn_if.free_empty), 1);
        check("x9_tag",            32'(rn_if.tag_rs1), 7);

        // Simultaneous alloc and free.
        drive(0, 0, 0, 0, 1, 50);
        drive(0, 10, 0, 0, 1, 40);
        check("sim_new",   32'(rn_if.tag_new), 50);
        check("sim_old",   32'(rn_if.tag_old), 10);
        drive(0, 11, 10, 0, 0, 0);
        check("sim_count_kept", 32'(rn_if.free_empty), 0);
        check("sim_tail_40",    32'(rn_if.tag_new), 40);
        check("x10_tag",        32'(rn_if.tag_rs1), 50);
        drive(0, 0, 11, 0, 0, 0);
        check("sim_drained", 32'(rn_if.free_empty), 1);
        check("x11_tag",     32'(rn_if.tag_rs1), 40);

        // Mid-sequence reset restores identity and the preload.
        do_reset();
        drive(0, 2, 2, 11, 0, 0);
        check("rst2_empty", 32'(rn_if.free_empty), 0);
        check("rst2_rs1",   32'(rn_if.tag_rs1), 2);
        check("rst2_rs2",   32'(rn_if.tag_rs2), 11);
        check("rst2_new",   32'(rn_if.tag_new), 32);
        check("rst2_old",   32'(rn_if.tag_old), 2);
        drive(0, 3, 2, 0, 0, 0);
        check("rst2_rs1_b", 32'(rn_if.tag_rs1), 32);
        check("rst2_new_b", 32'(rn_if.tag_new), 33);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/rename_unit.md
Name: rename_unit

Overview:
- Register-rename stage of the out-of-order RISC-V pipeline. It sits after decode and before dispatch.
- Maps 5-bit architectural register indices to 6-bit physical tags through a register alias table (RAT) and a FIFO free list.
- Each renamed destination gets a fresh physical tag. The unit also reports the previous mapping so commit can free that tag later.

Parameters:
- ARCH_REGS, 32, number of architectural registers.
- PHYS_REGS, 64, number of physical registers.
- TAG_W, 6, physical tag width; equals clog2(PHYS_REGS).

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- stall_in  in  1  hold; no RAT or free-list allocation this cycle.
- prd_free  in  TAG_W  physical tag being released by commit.
- commit_free  in  1  valid qualifier for prd_free.
- rd  in  5  destination architectural register; 0 means no destination.
- rs1  in  5  source 1 architectural register.
- rs2  in  5  source 2 architectural register.
- tag_new  out  TAG_W  newly allocated physical tag for rd.
- tag_old  out  TAG_W  previous physical mapping of rd.
- tag_rs1  out  TAG_W  physical tag for rs1.
- tag_rs2  out  TAG_W  physical tag for rs2.
- free_empty  out  1  free list has no entries.

Behaviour:
- Outputs are combinational from the current inputs and the current state. RAT and free list update only on posedge clk.
- Reset (rst=1 at posedge):
  - RAT[i]=i for i in 0..31.
  - Free list holds tags 32..63 in ascending order; head=32, count=32.
  - free_empty=0.
  - During reset all tag outputs reflect the reset state but no allocation occurs. Reset mid-operation discards all mappings and in-flight frees.
- Source lookup: tag_rs1=RAT[rs1], tag_rs2=RAT[rs2], read before this cycle's update. An instruction with rs==rd sees the old mapping. rs=0 always returns tag 0.
- Allocation condition: alloc = !stall_in && rd!=0 && !free_empty.
- When alloc:
  - tag_new = free-list head; tag_old = RAT[rd].
  - At posedge: RAT[rd] <= tag_new, head pops, count decrements.
- When not alloc: tag_new=0, tag_old=RAT[rd] (0 when rd=0); no state change.
- x0 is permanently mapped to tag 0 and is never allocated. Tag 0 is never placed in the free list.
- Free: commit_free=1 at posedge pushes prd_free at the tail, except when prd_free==0 or the list is full (count==PHYS_REGS-1). Those pushes are ignored.
- Freeing is independent of stall_in.
- Simultaneous alloc and free: both occur and count is unchanged.
- No bypass of a freed tag into the same cycle's allocation. When the list is empty and commit_free=1, free_empty stays 1 this cycle and clears next cycle.
- Upstream must stall while free_empty=1 and rd!=0. The unit itself silently drops the allocation in that case.
- Free list: circular buffer of PHYS_REGS entries with head/tail pointers of TAG_W bits that wrap modulo PHYS_REGS, plus a (TAG_W+1)-bit count.
- free_empty = (count==0).

Decomposition:
- Shared package rename_pkg holds ARCH_REGS, PHYS_REGS, TAG_W, typedef tag_t = logic [TAG_W-1:0], and typedef areg_t = logic [4:0].
- One sub-module, free_list: a FIFO with push/pop/empty/full and a reset preload of 32..63.
- The RAT stays inline as a 32-entry register array.

Test Plan:
- Reset, then rd=2, rs1=0, rs2=6 (addi x2,x0,6 = 0x00600113) -> tag_new=32, tag_old=2, tag_rs1=0, tag_rs2=6. Next cycle rd=3, rs1=0 (0x00f00193) -> tag_new=33, tag_old=3.
- Then rs1=2, rs2=3, rd=2 -> tag_rs1=32, tag_rs2=33, tag_new=34, tag_old=32.
- stall_in=1 with rd=5 -> tag_new=0, no allocation. Next unstalled rd=5 -> tag_new is the next sequential tag, tag_old=5.
- rd=0 -> tag_new=0 and the free list is untouched. Exhaust 32 allocations -> free_empty=1. A 33rd rd!=0 gets tag_new=0.
- While empty, commit_free=1 with prd_free=7 -> free_empty=0 next cycle; the next allocation yields tag_new=7. prd_free=0 with commit_free=1 is ignored.
- Simultaneous alloc and commit_free (prd_free=40) -> count unchanged and 40 is appended at the tail. Mid-sequence rst -> the RAT returns to identity and the next allocation is 32.
